// File: rtl/lookup_pkg.sv
// Shared definitions for the MAC lookup request arbiter: slot state encoding,
// tag layout on the lookup id bus and the MAC width.
package lookup_pkg;

  localparam int MAC_W       = 48;
  localparam int TAG_W       = 4;
  localparam int TAG_REQ_LSB = 0;
  localparam int TAG_REQ_MSB = 1;
  localparam int TAG_SEQ_LSB = 2;
  localparam int TAG_SEQ_MSB = 3;
  localparam int TIMER_W     = 8;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_WAIT = 1'b1
  } slot_state_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic [1:0] seq, input logic [1:0] req);
    return {seq, req};
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Pointer-based round-robin arbiter: grants the first eligible requester at or
// after the pointer, and moves the pointer past the winner only on accept.
module rr_arbiter_n
  import lookup_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_eligible,
  input  logic         i_accept,
  output logic [N-1:0] o_grant,
  output logic [1:0]   o_grant_idx,
  output logic         o_grant_valid
);

  logic [1:0] ptr_q;
  logic [3:0] elig4;
  logic [3:0] grant4;

  // Padding to four lanes keeps every 2-bit index in range for N below 4.
  assign elig4   = 4'(i_eligible);
  assign o_grant = grant4[N-1:0];

  always_comb begin
    logic [2:0] cand;
    grant4        = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    cand          = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_q} + 3'(off);
      if (cand >= 3'(N)) cand = cand - 3'(N);
      if (!o_grant_valid && elig4[cand[1:0]]) begin
        o_grant_valid        = 1'b1;
        o_grant_idx          = cand[1:0];
        grant4[cand[1:0]]    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else if (i_accept && o_grant_valid) begin
      ptr_q <= (o_grant_idx == 2'(N - 1)) ? 2'd0 : o_grant_idx + 2'd1;
    end
  end

endmodule

// File: rtl/lookup_req_arbiter.sv
// Shares one MAC lookup port among up to four requesters: round-robin issue,
// one outstanding lookup per requester, tag-steered results and per-slot timeout.
module lookup_req_arbiter
  import lookup_pkg::*;
#(
  parameter int P_NUM_REQ = 4,
  parameter int P_TIMEOUT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [P_NUM_REQ-1:0]       i_req_valid,
  input  logic [MAC_W*P_NUM_REQ-1:0] i_req_mac,
  output logic [P_NUM_REQ-1:0]       o_req_ready,
  output logic [MAC_W-1:0]           o_check_mac,
  output logic [TAG_W-1:0]           o_check_id,
  output logic                       o_check_valid,
  input  logic                       i_result_valid,
  input  logic [TAG_W-1:0]           i_check_id,
  input  logic [2:0]                 i_outport,
  input  logic [1:0]                 i_seek_flag,
  output logic [P_NUM_REQ-1:0]       o_rsp_valid,
  output logic [2:0]                 o_rsp_outport,
  output logic [1:0]                 o_rsp_seek_flag,
  output logic [P_NUM_REQ-1:0]       o_timeout_err,
  output logic                       o_busy
);

  slot_state_t          slot_q  [P_NUM_REQ];
  logic [1:0]           seq_q   [P_NUM_REQ];
  logic [TIMER_W-1:0]   timer_q [P_NUM_REQ];

  logic [P_NUM_REQ-1:0] eligible, grant, hit, wait_bits;
  logic [1:0]           grant_idx, seq_sel, res_req, res_seq;
  logic                 grant_valid, accept;
  logic [MAC_W-1:0]     mac_sel;

  assign res_req = i_check_id[TAG_REQ_MSB:TAG_REQ_LSB];
  assign res_seq = i_check_id[TAG_SEQ_MSB:TAG_SEQ_LSB];

  // Handshake: a request transfers in the cycle where i_req_valid[k] and
  // o_req_ready[k] are both high; ready is never conditioned on anything but
  // registered slot state and the current valids, and at most one bit is set.
  // A slot that just raised rsp_valid or timeout_err is held off for that
  // cycle so a freed slot is never re-granted in the cycle it reports.
  always_comb begin
    eligible  = '0;
    hit       = '0;
    wait_bits = '0;
    mac_sel   = '0;
    seq_sel   = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      wait_bits[k] = (slot_q[k] == SLOT_WAIT);
      eligible[k]  = i_req_valid[k] && (slot_q[k] == SLOT_IDLE) &&
                     !o_rsp_valid[k] && !o_timeout_err[k];
      hit[k]       = i_result_valid && (res_req == 2'(k)) &&
                     (slot_q[k] == SLOT_WAIT) && (res_seq == seq_q[k] - 2'd1);
      if (grant[k]) begin
        mac_sel = i_req_mac[MAC_W*k +: MAC_W];
        seq_sel = seq_q[k];
      end
    end
  end

  rr_arbiter_n #(.N(P_NUM_REQ)) u_rr (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_eligible    (eligible),
    .i_accept      (accept),
    .o_grant       (grant),
    .o_grant_idx   (grant_idx),
    .o_grant_valid (grant_valid)
  );

  assign accept      = grant_valid && !i_rst;
  assign o_req_ready = i_rst ? '0 : grant;
  assign o_busy      = |wait_bits;

  // Seq advances on the accept edge, so the issued tag carries the old value
  // and a live result is the one whose seq equals the current counter minus one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < P_NUM_REQ; k++) begin
        slot_q[k]  <= SLOT_IDLE;
        seq_q[k]   <= '0;
        timer_q[k] <= '0;
      end
      o_check_valid   <= 1'b0;
      o_check_mac     <= '0;
      o_check_id      <= '0;
      o_rsp_valid     <= '0;
      o_rsp_outport   <= '0;
      o_rsp_seek_flag <= '0;
      o_timeout_err   <= '0;
    end else begin
      o_check_valid <= accept;
      if (accept) begin
        o_check_mac <= mac_sel;
        o_check_id  <= make_tag(seq_sel, grant_idx);
      end
      o_rsp_valid <= hit;
      if (|hit) begin
        o_rsp_outport   <= i_outport;
        o_rsp_seek_flag <= i_seek_flag;
      end
      for (int k = 0; k < P_NUM_REQ; k++) begin
        o_timeout_err[k] <= 1'b0;
        case (slot_q[k])
          SLOT_IDLE: begin
            if (accept && grant[k]) begin
              slot_q[k]  <= SLOT_WAIT;
              timer_q[k] <= '0;
              seq_q[k]   <= seq_q[k] + 2'd1;
            end
          end
          SLOT_WAIT: begin
            if (hit[k]) begin
              slot_q[k] <= SLOT_IDLE;
            end else if (timer_q[k] == TIMER_W'(P_TIMEOUT - 1)) begin
              slot_q[k]        <= SLOT_IDLE;
              o_timeout_err[k] <= 1'b1;
            end else begin
              timer_q[k] <= timer_q[k] + 1'b1;
            end
          end
          default: slot_q[k] <= SLOT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lookup_req_arbiter.sv
// Bench for lookup_req_arbiter: two-stage engine model with a response
// scoreboard, a grant/issue vector table and hand sequences for corner cases.
module tb_lookup_req_arbiter;

  logic         i_clk;
  logic         i_rst;
  logic [3:0]   i_req_valid;
  logic [191:0] i_req_mac;
  logic [3:0]   o_req_ready;
  logic [47:0]  o_check_mac;
  logic [3:0]   o_check_id;
  logic         o_check_valid;
  logic         i_result_valid;
  logic [3:0]   i_check_id;
  logic [2:0]   i_outport;
  logic [1:0]   i_seek_flag;
  logic [3:0]   o_rsp_valid;
  logic [2:0]   o_rsp_outport;
  logic [1:0]   o_rsp_seek_flag;
  logic [3:0]   o_timeout_err;
  logic         o_busy;

  lookup_req_arbiter #(.P_NUM_REQ(4), .P_TIMEOUT(16)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .i_req_mac       (i_req_mac),
    .o_req_ready     (o_req_ready),
    .o_check_mac     (o_check_mac),
    .o_check_id      (o_check_id),
    .o_check_valid   (o_check_valid),
    .i_result_valid  (i_result_valid),
    .i_check_id      (i_check_id),
    .i_outport       (i_outport),
    .i_seek_flag     (i_seek_flag),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_outport   (o_rsp_outport),
    .o_rsp_seek_flag (o_rsp_seek_flag),
    .o_timeout_err   (o_timeout_err),
    .o_busy          (o_busy)
  );

  // ---------------- clock ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];   // {rsp_valid onehot, outport, seek}
  logic       inj_v, inj_exp;
  logic [3:0] inj_id;
  logic [3:0] withhold;
  logic       d1_v, d2_v;
  logic [3:0] d1_id, d2_id;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] rdy;
    logic       busy;
    logic       cv;
    logic [3:0] id;
  } vec_t;
  vec_t tbl[17];

  logic [3:0] exp_ids[5];
  logic [3:0] oh;
  int last_g, ng, ni, first_to;
  logic [3:0] to_val;

  function automatic logic [2:0] model_outport(input logic [3:0] id);
    return {1'b0, id[1:0]} ^ 3'd2;
  endfunction

  function automatic logic [8:0] model_rsp(input logic [3:0] id);
    logic [3:0] sel;
    sel = 4'b0001 << id[1:0];
    return {sel, model_outport(id), id[3:2]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic rand_macs();
    for (int k = 0; k < 4; k++)
      i_req_mac[48*k +: 48] = {16'($urandom_range(0, 65535)), 32'($urandom)};
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    i_req_valid = '0;
    inj_v       = 1'b0;
    inj_exp     = 1'b0;
    withhold    = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_state", 64'({o_req_ready, o_check_valid, o_check_id, o_rsp_valid, o_rsp_outport,
                            o_rsp_seek_flag, o_timeout_err, o_busy}), 64'(0));
    chk("reset_mac", 64'(o_check_mac), 64'(0));
    exp_q.delete();
    i_rst = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      next_cycle();
      i_req_valid = '0;
    end
    sample();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_idle", 64'(o_busy), 64'(0));
  endtask

  // ---------------- engine model: result two cycles after issue ----------------
  initial begin
    i_result_valid = 1'b0;
    i_check_id     = '0;
    i_outport      = '0;
    i_seek_flag    = '0;
    d1_v = 1'b0; d2_v = 1'b0; d1_id = '0; d2_id = '0;
    forever begin
      @(posedge i_clk);
      #2;
      if (i_rst) begin
        d1_v = 1'b0;
        d2_v = 1'b0;
        i_result_valid = 1'b0;
      end else begin
        if (inj_v) begin
          i_result_valid = 1'b1;
          i_check_id     = inj_id;
          i_outport      = model_outport(inj_id);
          i_seek_flag    = inj_id[3:2];
          if (inj_exp) exp_q.push_back(model_rsp(inj_id));
        end else if (d2_v && !withhold[d2_id[1:0]]) begin
          i_result_valid = 1'b1;
          i_check_id     = d2_id;
          i_outport      = model_outport(d2_id);
          i_seek_flag    = d2_id[3:2];
          exp_q.push_back(model_rsp(d2_id));
        end else begin
          i_result_valid = 1'b0;
        end
        d2_v  = d1_v;
        d2_id = d1_id;
        d1_v  = o_check_valid;
        d1_id = o_check_id;
      end
    end
  end

  // ---------------- response scoreboard ----------------
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge i_clk);
      if (!i_rst && (o_rsp_valid != '0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=0x%0h, required none", o_rsp_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_scoreboard", 64'({o_rsp_valid, o_rsp_outport, o_rsp_seek_flag}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    i_rst = 1'b1; i_req_valid = '0; i_req_mac = '0;
    inj_v = 1'b0; inj_exp = 1'b0; inj_id = '0; withhold = '0;

    //          valid  ready  busy  cv    id
    tbl[0]  = '{4'hF, 4'h1, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{4'hF, 4'h2, 1'b1, 1'b1, 4'h0};
    tbl[2]  = '{4'hF, 4'h4, 1'b1, 1'b1, 4'h1};
    tbl[3]  = '{4'hF, 4'h8, 1'b1, 1'b1, 4'h2};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h3};
    tbl[5]  = '{4'hF, 4'h1, 1'b1, 1'b0, 4'h0};
    tbl[6]  = '{4'hF, 4'h2, 1'b1, 1'b1, 4'h4};
    tbl[7]  = '{4'hF, 4'h4, 1'b1, 1'b1, 4'h5};
    tbl[8]  = '{4'hF, 4'h8, 1'b1, 1'b1, 4'h6};
    tbl[9]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h7};
    tbl[10] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[11] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[12] = '{4'hA, 4'h2, 1'b0, 1'b0, 4'h0};
    tbl[13] = '{4'hA, 4'h8, 1'b1, 1'b1, 4'h9};
    tbl[14] = '{4'h5, 4'h1, 1'b1, 1'b1, 4'hB};
    tbl[15] = '{4'h5, 4'h4, 1'b1, 1'b1, 4'h8};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hA};
    exp_ids = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};

    // Single lookup with fixed latency
    do_reset();
    next_cycle();
    i_req_valid = 4'b0001;
    i_req_mac[47:0] = 48'h8DBC5C4A0201;
    sample();
    chk("t1_ready", 64'(o_req_ready), 64'(4'b0001));
    next_cycle();
    i_req_valid = '0;
    i_req_mac   = '1;
    sample();
    chk("t1_issue", 64'({o_check_valid, o_check_id}), 64'(5'b1_0000));
    chk("t1_mac", 64'(o_check_mac), 64'(48'h8DBC5C4A0201));
    next_cycle();
    sample();
    chk("t1_mac_hold", 64'({o_check_valid, o_check_mac}), 64'({1'b0, 48'h8DBC5C4A0201}));
    next_cycle();
    sample();
    chk("t1_no_early_rsp", 64'(o_rsp_valid), 64'(0));
    next_cycle();
    sample();
    chk("t1_rsp", 64'({o_rsp_valid, o_rsp_outport, o_rsp_seek_flag}), 64'({4'b0001, 3'd2, 2'd0}));
    drain(4);

    // Grant/issue vector table from reset
    do_reset();
    for (int i = 0; i < 17; i++) begin
      next_cycle();
      i_req_valid = tbl[i].valid;
      rand_macs();
      sample();
      chk($sformatf("t2_ready[%0d]", i), 64'(o_req_ready), 64'(tbl[i].rdy));
      chk($sformatf("t2_busy[%0d]", i), 64'(o_busy), 64'(tbl[i].busy));
      chk($sformatf("t2_cv[%0d]", i), 64'(o_check_valid), 64'(tbl[i].cv));
      if (tbl[i].cv) chk($sformatf("t2_id[%0d]", i), 64'(o_check_id), 64'(tbl[i].id));
    end
    drain(10);

    // Timeout on withheld result, then late result dropped
    do_reset();
    withhold = 4'b0010;
    next_cycle();
    i_req_valid = 4'b0010;
    sample();
    chk("t3_ready", 64'(o_req_ready), 64'(4'b0010));
    first_to = 0;
    to_val   = '0;
    for (int j = 1; j <= 24; j++) begin
      next_cycle();
      i_req_valid = '0;
      sample();
      if ((o_timeout_err != '0) && (first_to == 0)) begin
        first_to = j;
        to_val   = o_timeout_err;
      end
      if (j == 16) chk("t3_busy_before_to", 64'(o_busy), 64'(1));
      if (j == 17) chk("t3_busy_after_to", 64'(o_busy), 64'(0));
    end
    chk("t3_to_cycle", 64'(first_to), 64'(17));
    chk("t3_to_vec", 64'(to_val), 64'(4'b0010));
    next_cycle();
    inj_v = 1'b1; inj_exp = 1'b0; inj_id = 4'h1;
    next_cycle();
    inj_v = 1'b0;
    sample();
    chk("t3_late_dropped", 64'(o_rsp_valid), 64'(0));
    drain(3);

    // Result in the same cycle the timer expires: result wins
    do_reset();
    withhold = 4'b0100;
    next_cycle();
    i_req_valid = 4'b0100;
    sample();
    chk("t4_ready", 64'(o_req_ready), 64'(4'b0100));
    for (int j = 1; j <= 15; j++) begin
      next_cycle();
      i_req_valid = '0;
    end
    next_cycle();
    inj_v = 1'b1; inj_exp = 1'b1; inj_id = 4'h2;
    sample();
    chk("t4_no_early_to", 64'(o_timeout_err), 64'(0));
    next_cycle();
    inj_v = 1'b0;
    sample();
    chk("t4_rsp_wins", 64'({o_rsp_valid, o_rsp_outport, o_timeout_err}), 64'({4'b0100, 3'd0, 4'b0000}));
    next_cycle();
    sample();
    chk("t4_no_late_to", 64'({o_timeout_err, o_busy}), 64'(0));
    drain(3);

    // Back-to-back lookups on one requester with seq wrap
    do_reset();
    last_g = 0; ng = 0; ni = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      i_req_valid = (ng < 5) ? 4'b0001 : 4'b0000;
      rand_macs();
      sample();
      if (o_req_ready[0]) begin
        if (ng > 0) chk("t5_grant_gap", 64'(c - last_g), 64'(5));
        last_g = c;
        ng++;
      end
      if (o_check_valid && (ni < 5)) begin
        chk($sformatf("t5_id[%0d]", ni), 64'(o_check_id), 64'(exp_ids[ni]));
        ni++;
      end
    end
    chk("t5_grants", 64'(ng), 64'(5));
    chk("t5_issues", 64'(ni), 64'(5));
    drain(2);

    // Async reset with three slots waiting
    do_reset();
    withhold = 4'hF;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      i_req_valid = 4'b0111;
      sample();
      oh = 4'b0001 << c;
      chk($sformatf("t6_grant[%0d]", c), 64'(o_req_ready), 64'(oh));
    end
    next_cycle();
    i_req_valid = '0;
    #1;
    chk("t6_pre_reset", 64'({o_busy, o_check_valid}), 64'(2'b11));
    #1;
    i_rst = 1'b1;
    #1;
    chk("t6_async_reset", 64'({o_req_ready, o_check_valid, o_check_id, o_rsp_valid, o_rsp_outport,
                               o_rsp_seek_flag, o_timeout_err, o_busy}), 64'(0));
    chk("t6_async_mac", 64'(o_check_mac), 64'(0));
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      inj_v = 1'b1; inj_exp = 1'b0; inj_id = 4'(k);
      next_cycle();
      inj_v = 1'b0;
      sample();
      chk($sformatf("t6_stale_drop[%0d]", k), 64'(o_rsp_valid), 64'(0));
    end
    withhold = '0;
    next_cycle();
    i_req_valid = 4'hF;
    sample();
    chk("t6_regrant", 64'(o_req_ready), 64'(4'b0001));
    next_cycle();
    i_req_valid = '0;
    sample();
    chk("t6_reissue", 64'({o_check_valid, o_check_id}), 64'(5'b1_0000));
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
